packet_switch_egress_arbiter: RTL and testbench
===============================================

# packet_switch_egress_arbiter

Per-egress-port scheduler for the 4-port packet switch. Each instance watches all ingress streams leaving the filter, selects among those whose `tdest` names its port using frame-granular round-robin, and passes the winner's beats to its egress port until `tlast`. A stall timeout terminates and flushes frames whose source stops sending mid-frame, so a dead ingress port cannot block an egress port. The switch top instantiates one instance per egress port, with `PORT_ID` = 0..3.

## Interface
- `N_PORTS`, 4: number of ingress requesters.
- `DATA_WIDTH`, 16: stream data width.
- `IDX_WIDTH`, 2: width of `tdest` and of the grant index.
- `PORT_ID`, 0: egress index this instance serves.
- `TIMEOUT_CTR_WIDTH`, 9: width of the stall counter. Timeout fires after 2^W − 1 consecutive idle cycles (511 at the default).

- `clk` input 1: the single clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_tdata` input N_PORTS*DATA_WIDTH: ingress data, packed; port i occupies slice i.
- `in_tvalid` input N_PORTS: ingress valid.
- `in_tlast` input N_PORTS: ingress end of frame.
- `in_tdest` input N_PORTS*IDX_WIDTH: ingress destination, packed.
- `in_tready` output N_PORTS: per-ingress ready; at most one bit set.
- `out_tdata` output DATA_WIDTH: egress data.
- `out_tvalid` output 1: egress valid.
- `out_tlast` output 1: egress end of frame.
- `out_tready` input 1: egress ready.
- `grant_valid` output 1: a frame is currently owned.
- `grant_idx` output IDX_WIDTH: the owning ingress index.
- `frames_fwd` output 16: frames completed normally; wraps.
- `frames_abort` output 16: frames terminated by timeout; wraps.
- `timeout_evt` output 1: one-cycle pulse when a timeout fires.

## Operation
- Request vector: `req[i] = in_tvalid[i] && in_tdest[i] == PORT_ID`.
- `tdest` is evaluated only in IDLE; it is ignored for the rest of a frame.
- **IDLE**
  - All outputs are quiet: `in_tready` = 0, `out_tvalid` = 0.
  - If any `req` bit is set, register the grant = first requester searching from `last_grant+1` upward, modulo N_PORTS. Go to XFER.
  - No beat is accepted in the arbitration cycle.
- **XFER**
  - Combinational pass-through from ingress g = `grant_idx`: `out_tdata/tvalid/tlast` = ingress g; `in_tready[g] = out_tready`; all other ready bits are 0.
  - A beat transfers when `out_tvalid && out_tready`.
  - A beat with `tlast`: increment `frames_fwd`, set `last_grant` = g, go to IDLE.
  - Stall counter:
    - Resets to 0 on every transferred beat, and on entry to XFER.
    - Increments on each cycle where `in_tvalid[g]` = 0.
    - Holds while `in_tvalid[g]` = 1 and `out_tready` = 0 (egress backpressure never times out).
  - Counter reaches all-ones: pulse `timeout_evt`, go to TERM.
- **TERM**
  - Drive `out_tvalid` = 1, `out_tlast` = 1, `out_tdata` = 0; `in_tready` = 0.
  - On `out_tready`: increment `frames_abort`, go to FLUSH.
- **FLUSH**
  - `in_tready[g]` = 1 and `out_tvalid` = 0; beats from g are discarded.
  - On a discarded beat with `tlast`: set `last_grant` = g, go to IDLE.
- Reset values: state IDLE; `last_grant` = N_PORTS−1, so port 0 wins first; counters 0; `grant_valid` = 0; `grant_idx` = 0; `timeout_evt` = 0; all stream outputs 0.
- `grant_valid` = 1 in XFER, TERM and FLUSH.

## Timing
- Arbitration latency: 1 cycle from the first `req` to the first possible beat.
- Frame-to-frame gap: 1 idle cycle (the IDLE state) between back-to-back frames.
- Data path latency is 0 cycles; no data register.
- AXI-Stream rules hold: `out_tvalid` is never withdrawn without a transfer while in XFER if ingress obeys the protocol. TERM holds valid until accepted.
- Simultaneous requests: resolved purely by rotation. A requester that appears mid-frame waits for the current frame to finish.
- Single-beat frame (`tlast` on the first beat): legal. The frame takes the arbitration cycle plus one beat, then returns to IDLE.
- Reset asserted mid-frame: immediate return to reset values, with no terminating beat. The downstream frame boundary is the environment's concern.
- `timeout_evt` and the `frames_abort` increment are separate events, separated by TERM's handshake.

## Structure
- Shared package `packet_switch_pkg`:
  - state enum `arb_state_t` {IDLE, XFER, TERM, FLUSH};
  - `PKT_CTR_WIDTH` = 16;
  - default `N_PORTS`, `IDX_WIDTH` and `DATA_WIDTH` constants, shared with `packet_switch`.
- Sub-module `packet_switch_rr_arbiter`: purely combinational rotate-priority select. Inputs are `req` and `last_grant`; outputs are `any` and `idx`. It is reused by other switch schedulers.

## Test plan
- **Contention:** ports 0 and 2 both target PORT_ID=1 with 3-beat frames 0xA000.. and 0xC000.. → egress carries port 0's frame then port 2's frame, one idle cycle between them, `frames_fwd` = 2.
- **Rotation fairness:** all 4 ports continuously send 1-beat frames to PORT_ID → grant order 0,1,2,3,0 and every port gets an equal share of beats.
- **Backpressure:** `out_tready` held low for 600 cycles mid-frame with `in_tvalid` high → no timeout, and the frame completes intact once ready returns.
- **Stall timeout:** granted ingress drops `tvalid` after 2 beats → `timeout_evt` pulses after 511 idle cycles; egress shows beat 0x0000 with `tlast`; remaining ingress beats are sunk up to `tlast`; `frames_abort` = 1.
- **Destination filtering:** port 3 sends frames with `tdest` = 2 to a PORT_ID=1 instance → `in_tready[3]` stays 0, `out_tvalid` stays 0, counters unchanged.
- **Reset mid-frame:** `reset_n` driven low during beat 2 → all outputs return to reset values; after release, port 0 is granted first.

Source files
------------

// File: rtl/packet_switch_pkg.sv
// Shared definitions for the packet switch: scheduler state encoding,
// statistics counter width and default stream geometry.
package packet_switch_pkg;

    localparam int DEF_N_PORTS    = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_IDX_WIDTH  = 2;
    localparam int PKT_CTR_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        TERM  = 2'd2,
        FLUSH = 2'd3
    } arb_state_t;

endpackage

// File: rtl/packet_switch_egress_arbiter_if.sv
// Stream bundle between the ingress filters, one egress arbiter and its
// egress port. The arbiter sits on the slave side.
interface packet_switch_egress_arbiter_if
    import packet_switch_pkg::*;
#(
    parameter int N_PORTS    = DEF_N_PORTS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) ();

    logic [N_PORTS*DATA_WIDTH-1:0] in_tdata;
    logic [N_PORTS-1:0]            in_tvalid;
    logic [N_PORTS-1:0]            in_tlast;
    logic [N_PORTS*IDX_WIDTH-1:0]  in_tdest;
    logic [N_PORTS-1:0]            in_tready;
    logic [DATA_WIDTH-1:0]         out_tdata;
    logic                          out_tvalid;
    logic                          out_tlast;
    logic                          out_tready;

    modport master (
        output in_tdata, in_tvalid, in_tlast, in_tdest, out_tready,
        input  in_tready, out_tdata, out_tvalid, out_tlast
    );

    modport slave (
        input  in_tdata, in_tvalid, in_tlast, in_tdest, out_tready,
        output in_tready, out_tdata, out_tvalid, out_tlast
    );

endinterface

// File: rtl/packet_switch_rr_arbiter.sv
// Combinational rotate-priority select: first requester strictly after
// last_grant, wrapping modulo N_PORTS.
module packet_switch_rr_arbiter
    import packet_switch_pkg::*;
#(
    parameter int N_PORTS   = DEF_N_PORTS,
    parameter int IDX_WIDTH = DEF_IDX_WIDTH
) (
    input  logic [N_PORTS-1:0]   req,
    input  logic [IDX_WIDTH-1:0] last_grant,
    output logic                 any,
    output logic [IDX_WIDTH-1:0] idx
);

    logic [IDX_WIDTH-1:0] cand_s;

    // Scan from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        any    = 1'b0;
        idx    = {IDX_WIDTH{1'b0}};
        cand_s = {IDX_WIDTH{1'b0}};
        for (int off = N_PORTS; off > 0; off--) begin
            cand_s = IDX_WIDTH'((int'(last_grant) + off) % N_PORTS);
            if (req[cand_s]) begin
                any = 1'b1;
                idx = cand_s;
            end else begin
                any = any;
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/packet_switch_egress_arbiter.sv
// Per-egress-port frame scheduler: round-robin frame grant, zero-latency
// pass-through, and stall timeout that terminates and flushes dead frames.
module packet_switch_egress_arbiter
    import packet_switch_pkg::*;
#(
    parameter int N_PORTS           = DEF_N_PORTS,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int IDX_WIDTH         = DEF_IDX_WIDTH,
    parameter int PORT_ID           = 0,
    parameter int TIMEOUT_CTR_WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         reset_n,
    packet_switch_egress_arbiter_if.slave bus,
    output logic                         grant_valid,
    output logic [IDX_WIDTH-1:0]         grant_idx,
    output logic [PKT_CTR_WIDTH-1:0]     frames_fwd,
    output logic [PKT_CTR_WIDTH-1:0]     frames_abort,
    output logic                         timeout_evt
);

    arb_state_t                   state_r, state_nx_s;
    logic [N_PORTS-1:0]           req_s;
    logic                         rr_any_s;
    logic [IDX_WIDTH-1:0]         rr_idx_s;
    logic [IDX_WIDTH-1:0]         grant_r, last_grant_r;
    logic                         grant_valid_r, timeout_evt_r;
    logic [TIMEOUT_CTR_WIDTH-1:0] stall_r;
    logic [PKT_CTR_WIDTH-1:0]     fwd_r, abort_r;
    logic [N_PORTS-1:0]           grant_oh_s;
    logic [DATA_WIDTH-1:0]        g_tdata_s;
    logic                         g_tvalid_s, g_tlast_s;
    logic                         beat_s, stall_max_s;
    logic [N_PORTS-1:0]           in_tready_s;
    logic [DATA_WIDTH-1:0]        out_tdata_s;
    logic                         out_tvalid_s, out_tlast_s;

    // Requests, and the ingress stream selected by the current grant.
    always_comb begin
        req_s      = {N_PORTS{1'b0}};
        grant_oh_s = {N_PORTS{1'b0}};
        g_tdata_s  = {DATA_WIDTH{1'b0}};
        g_tvalid_s = 1'b0;
        g_tlast_s  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            req_s[i] = bus.in_tvalid[i] &&
                       (bus.in_tdest[i*IDX_WIDTH +: IDX_WIDTH] == IDX_WIDTH'(PORT_ID));
            if (grant_r == IDX_WIDTH'(i)) begin
                grant_oh_s[i] = 1'b1;
                g_tdata_s     = bus.in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                g_tvalid_s    = bus.in_tvalid[i];
                g_tlast_s     = bus.in_tlast[i];
            end else begin
                grant_oh_s[i] = 1'b0;
            end
        end
    end

    packet_switch_rr_arbiter #(
        .N_PORTS   (N_PORTS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr (
        .req        (req_s),
        .last_grant (last_grant_r),
        .any        (rr_any_s),
        .idx        (rr_idx_s)
    );

    assign beat_s      = (state_r == XFER) && g_tvalid_s && bus.out_tready;
    assign stall_max_s = &stall_r;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a transferring beat always wins over the timeout.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (rr_any_s) state_nx_s = XFER;
                else          state_nx_s = IDLE;
            end
            XFER: begin
                if (beat_s && g_tlast_s)         state_nx_s = IDLE;
                else if (!beat_s && stall_max_s) state_nx_s = TERM;
                else                             state_nx_s = XFER;
            end
            TERM: begin
                if (bus.out_tready) state_nx_s = FLUSH;
                else                state_nx_s = TERM;
            end
            FLUSH: begin
                if (g_tvalid_s && g_tlast_s) state_nx_s = IDLE;
                else                         state_nx_s = FLUSH;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Stream outputs: pass-through in XFER, synthetic last beat in TERM, sink in FLUSH.
    always_comb begin
        in_tready_s  = {N_PORTS{1'b0}};
        out_tdata_s  = {DATA_WIDTH{1'b0}};
        out_tvalid_s = 1'b0;
        out_tlast_s  = 1'b0;
        case (state_r)
            IDLE: begin
                in_tready_s = {N_PORTS{1'b0}};
            end
            XFER: begin
                out_tdata_s  = g_tdata_s;
                out_tvalid_s = g_tvalid_s;
                out_tlast_s  = g_tlast_s;
                in_tready_s  = grant_oh_s & {N_PORTS{bus.out_tready}};
            end
            TERM: begin
                out_tvalid_s = 1'b1;
                out_tlast_s  = 1'b1;
            end
            FLUSH: begin
                in_tready_s = grant_oh_s;
            end
            default: begin
                in_tready_s = {N_PORTS{1'b0}};
            end
        endcase
    end

    // Grant bookkeeping, stall counter and frame statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_r       <= {IDX_WIDTH{1'b0}};
            last_grant_r  <= IDX_WIDTH'(N_PORTS - 1);
            grant_valid_r <= 1'b0;
            timeout_evt_r <= 1'b0;
            stall_r       <= {TIMEOUT_CTR_WIDTH{1'b0}};
            fwd_r         <= {PKT_CTR_WIDTH{1'b0}};
            abort_r       <= {PKT_CTR_WIDTH{1'b0}};
        end else begin
            grant_valid_r <= (state_nx_s != IDLE);
            timeout_evt_r <= (state_r == XFER) && (state_nx_s == TERM);
            case (state_r)
                IDLE: begin
                    if (rr_any_s) begin
                        grant_r <= rr_idx_s;
                        stall_r <= {TIMEOUT_CTR_WIDTH{1'b0}};
                    end
                end
                XFER: begin
                    if (beat_s) begin
                        stall_r <= {TIMEOUT_CTR_WIDTH{1'b0}};
                        if (g_tlast_s) begin
                            fwd_r        <= fwd_r + PKT_CTR_WIDTH'(1);
                            last_grant_r <= grant_r;
                        end
                    end else if (!g_tvalid_s) begin
                        stall_r <= stall_r + TIMEOUT_CTR_WIDTH'(1);
                    end
                end
                TERM: begin
                    if (bus.out_tready) begin
                        abort_r <= abort_r + PKT_CTR_WIDTH'(1);
                    end
                end
                FLUSH: begin
                    if (g_tvalid_s && g_tlast_s) begin
                        last_grant_r <= grant_r;
                    end
                end
                default: begin
                    stall_r <= {TIMEOUT_CTR_WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign bus.in_tready  = in_tready_s;
    assign bus.out_tdata  = out_tdata_s;
    assign bus.out_tvalid = out_tvalid_s;
    assign bus.out_tlast  = out_tlast_s;
    assign grant_valid    = grant_valid_r;
    assign grant_idx      = grant_r;
    assign frames_fwd     = fwd_r;
    assign frames_abort   = abort_r;
    assign timeout_evt    = timeout_evt_r;

endmodule

// File: tb/tb_packet_switch_egress_arbiter.sv
// Directed bench for the egress arbiter (PORT_ID = 1): a per-cycle vector
// table for contention/filtering plus sequences for the multi-cycle cases.
module tb_packet_switch_egress_arbiter;
    import packet_switch_pkg::*;

    localparam int NP = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic [15:0]   frames_fwd, frames_abort;
    logic          timeout_evt;

    always #5 clk = ~clk;

    packet_switch_egress_arbiter_if #(.N_PORTS(NP), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

    packet_switch_egress_arbiter #(
        .N_PORTS(NP), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .PORT_ID(1), .TIMEOUT_CTR_WIDTH(9)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .frames_fwd   (frames_fwd),
        .frames_abort (frames_abort),
        .timeout_evt  (timeout_evt)
    );

    typedef struct packed {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [7:0]  dst;
        logic [11:0] beat;
        logic        rdy;
        logic [3:0]  e_irdy;
        logic        e_ovld;
        logic        e_olst;
        logic [15:0] e_odata;
        logic        e_gv;
        logic [1:0]  e_gi;
    } vec_t;

    vec_t        tbl [13];
    int          n_vec = 0;
    int          n_bad = 0;

    logic        s_fire, s_ovld, s_olst, s_gv, s_tmo;
    logic [15:0] s_odata, s_fwd, s_abort;
    logic [3:0]  s_irdy;
    logic [1:0]  s_gi;

    // Port p carries 0xA000 + p*0x1000 + beat, so every beat names its source.
    task automatic set_in(input logic [3:0] vld, input logic [3:0] lst, input logic [7:0] dst,
                          input logic [11:0] beat, input logic rdy);
        for (int p = 0; p < NP; p++) begin
            bus.in_tdata[p*DW +: DW] = 16'hA000 + (16'(p) << 12) + {4'h0, beat};
        end
        bus.in_tvalid  = vld;
        bus.in_tlast   = lst;
        bus.in_tdest   = dst;
        bus.out_tready = rdy;
    endtask

    // Sample mid-cycle, then let the next rising edge happen.
    task automatic tick();
        @(negedge clk);
        #1;
        s_fire  = bus.out_tvalid && bus.out_tready;
        s_ovld  = bus.out_tvalid;
        s_olst  = bus.out_tlast;
        s_odata = bus.out_tdata;
        s_irdy  = bus.in_tready;
        s_gv    = grant_valid;
        s_gi    = grant_idx;
        s_tmo   = timeout_evt;
        s_fwd   = frames_fwd;
        s_abort = frames_abort;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nt, k;
        logic [1:0] ep;

        //       vld      lst      dst    beat    rdy   irdy     ovld  olst  odata     gv    gi
        tbl[0]  = '{4'b0101, 4'b0000, 8'h11, 12'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0};
        tbl[1]  = '{4'b0101, 4'b0000, 8'h11, 12'd0, 1'b1, 4'b0001, 1'b1, 1'b0, 16'hA000, 1'b1, 2'd0};
        tbl[2]  = '{4'b0101, 4'b0000, 8'h11, 12'd1, 1'b0, 4'b0000, 1'b1, 1'b0, 16'hA001, 1'b1, 2'd0};
        tbl[3]  = '{4'b0101, 4'b0000, 8'h11, 12'd1, 1'b1, 4'b0001, 1'b1, 1'b0, 16'hA001, 1'b1, 2'd0};
        tbl[4]  = '{4'b0101, 4'b0001, 8'h11, 12'd2, 1'b1, 4'b0001, 1'b1, 1'b1, 16'hA002, 1'b1, 2'd0};
        tbl[5]  = '{4'b0100, 4'b0000, 8'h11, 12'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0};
        tbl[6]  = '{4'b0100, 4'b0000, 8'h11, 12'd0, 1'b1, 4'b0100, 1'b1, 1'b0, 16'hC000, 1'b1, 2'd2};
        tbl[7]  = '{4'b0100, 4'b0000, 8'h11, 12'd1, 1'b1, 4'b0100, 1'b1, 1'b0, 16'hC001, 1'b1, 2'd2};
        tbl[8]  = '{4'b0100, 4'b0100, 8'h11, 12'd2, 1'b1, 4'b0100, 1'b1, 1'b1, 16'hC002, 1'b1, 2'd2};
        tbl[9]  = '{4'b0000, 4'b0000, 8'h11, 12'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd2};
        tbl[10] = '{4'b1000, 4'b1000, 8'h80, 12'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd2};
        tbl[11] = '{4'b1000, 4'b0000, 8'h80, 12'd1, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd2};
        tbl[12] = '{4'b1000, 4'b1000, 8'h80, 12'd2, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd2};

        reset_n = 1'b0;
        set_in(4'b0000, 4'b0000, 8'h00, 12'd0, 1'b0);
        tick();
        chk("reset_state", {s_gv, s_gi, s_ovld, s_olst, s_odata, s_irdy, s_fwd, s_abort, s_tmo}, 64'd0);
        tick();
        reset_n = 1'b1;

        // Contention between ports 0 and 2, then destination filtering of port 3.
        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].vld, tbl[i].lst, tbl[i].dst, tbl[i].beat, tbl[i].rdy);
            tick();
            chk($sformatf("row%0d", i),
                {s_irdy, s_ovld, s_olst, s_odata, s_gv, s_gi},
                {tbl[i].e_irdy, tbl[i].e_ovld, tbl[i].e_olst, tbl[i].e_odata, tbl[i].e_gv, tbl[i].e_gi});
        end
        chk("contention_counters", {s_fwd, s_abort, s_tmo}, {16'd2, 16'd0, 1'b0});

        // Rotation fairness from reset: all four ports stream 1-beat frames.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_in(4'b1111, 4'b1111, 8'h55, 12'd0, 1'b1);
        nb = 0;
        nt = 0;
        while (nb < 16 && nt < 100) begin
            tick();
            nt++;
            if (s_fire) begin
                ep = 2'(nb % 4);
                chk($sformatf("rr_beat%0d", nb), {s_gi, s_irdy, s_olst, s_odata},
                    {ep, 4'b0001 << ep, 1'b1, 16'hA000 + (16'(ep) << 12)});
                nb++;
            end
        end
        chk("rr_cycles", 64'(nt), 64'd32);
        set_in(4'b0000, 4'b0000, 8'h55, 12'd0, 1'b1);
        tick();
        chk("rr_fwd", {s_fwd, s_gv}, {16'd16, 1'b0});

        // Backpressure: 600 stalled cycles mid-frame must not time out.
        set_in(4'b0001, 4'b0000, 8'h55, 12'd0, 1'b1);
        tick();
        tick();
        chk("bp_beat0", {s_fire, s_odata}, {1'b1, 16'hA000});
        set_in(4'b0001, 4'b0000, 8'h55, 12'd1, 1'b0);
        k = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (s_fire || s_tmo || !s_gv || !s_ovld) k++;
        end
        chk("bp_hold", 64'(k), 64'd0);
        set_in(4'b0001, 4'b0000, 8'h55, 12'd1, 1'b1);
        tick();
        chk("bp_beat1", {s_fire, s_olst, s_odata}, {1'b1, 1'b0, 16'hA001});
        set_in(4'b0001, 4'b0001, 8'h55, 12'd2, 1'b1);
        tick();
        chk("bp_beat2", {s_fire, s_olst, s_odata}, {1'b1, 1'b1, 16'hA002});
        set_in(4'b0000, 4'b0000, 8'h55, 12'd0, 1'b1);
        tick();
        chk("bp_counters", {s_fwd, s_abort, s_gv}, {16'd17, 16'd0, 1'b0});

        // Stall timeout: port 1 sends two beats, then goes silent.
        set_in(4'b0010, 4'b0000, 8'h55, 12'd0, 1'b1);
        tick();
        tick();
        chk("to_beat0", {s_fire, s_gi, s_odata}, {1'b1, 2'd1, 16'hB000});
        set_in(4'b0010, 4'b0000, 8'h55, 12'd1, 1'b1);
        tick();
        chk("to_beat1", {s_fire, s_odata}, {1'b1, 16'hB001});
        set_in(4'b0000, 4'b0000, 8'h55, 12'd2, 1'b1);
        k = 0;
        s_tmo = 1'b0;
        while (!s_tmo && k < 600) begin
            tick();
            k++;
        end
        chk("to_latency", 64'(k >= 511 && k <= 514), 64'd1);
        chk("to_term_beat", {s_ovld, s_olst, s_odata, s_irdy, s_gv}, {1'b1, 1'b1, 16'h0000, 4'b0000, 1'b1});
        set_in(4'b0010, 4'b0000, 8'h55, 12'd2, 1'b1);
        tick();
        chk("to_flush0", {s_tmo, s_irdy, s_ovld, s_abort}, {1'b0, 4'b0010, 1'b0, 16'd1});
        set_in(4'b0010, 4'b0010, 8'h55, 12'd3, 1'b1);
        tick();
        chk("to_flush1", {s_irdy, s_ovld, s_gv}, {4'b0010, 1'b0, 1'b1});
        set_in(4'b0000, 4'b0000, 8'h55, 12'd0, 1'b1);
        tick();
        chk("to_counters", {s_fwd, s_abort, s_gv}, {16'd17, 16'd1, 1'b0});

        // Reset during beat 2 of a port-2 frame; port 0 must win afterwards.
        set_in(4'b0101, 4'b0000, 8'h55, 12'd0, 1'b1);
        tick();
        tick();
        chk("rst_beat0", {s_fire, s_gi, s_odata}, {1'b1, 2'd2, 16'hC000});
        set_in(4'b0101, 4'b0000, 8'h55, 12'd1, 1'b1);
        tick();
        set_in(4'b0101, 4'b0000, 8'h55, 12'd2, 1'b1);
        reset_n = 1'b0;
        tick();
        chk("rst_values", {s_gv, s_gi, s_ovld, s_olst, s_odata, s_irdy, s_fwd, s_abort, s_tmo}, 64'd0);
        reset_n = 1'b1;
        set_in(4'b0101, 4'b0000, 8'h55, 12'd0, 1'b1);
        tick();
        chk("rst_idle", {s_gv, s_ovld}, {1'b0, 1'b0});
        tick();
        chk("rst_first_grant", {s_fire, s_gi, s_irdy, s_odata}, {1'b1, 2'd0, 4'b0001, 16'hA000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
